// File: rtl/sid_svf_mixer.sv
// Voice mixer and time-multiplexed state-variable filter (high/band/low) with master volume.
// Define SID_SVF_SAT_EN to clamp the output sample instead of letting it wrap.
module sid_svf_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int SAMPLE_W   = 12,
    parameter int OUT_W      = 16,
    parameter int STATE_W    = 32,
    parameter int FC_W       = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_enable,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
    input  logic [NUM_VOICES-1:0]          filt_sel,
    input  logic [NUM_VOICES-1:0]          voice_mute,
    input  logic [FC_W-1:0]                reg_fc,
    input  logic [3:0]                     res,
    input  logic [2:0]                     mode,
    input  logic [3:0]                     vol,
    output logic signed [OUT_W-1:0]        sample_out,
    output logic                           sample_valid
);

    localparam int AW  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
    localparam int VW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PW  = 18 + STATE_W;
    localparam int MW  = STATE_W + 2;   // three taps summed without overflow
    localparam int SCW = MW + 1;
    localparam logic signed [SCW-1:0] OUT_MAX = {{(SCW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SCW-1:0] OUT_MIN = {{(SCW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_ACC, S_HIGH, S_LOW, S_BAND, S_MIX, S_VOL, S_OUT
    } state_t;

    state_t          state, state_next;
    logic [VW-1:0]   vidx, vidx_next;

    logic [NUM_VOICES-1:0] filt_sh, mute_sh;
    logic [FC_W-1:0]       fc_sh;
    logic [3:0]            res_sh, vol_sh;
    logic [2:0]            mode_sh;

    logic signed [AW-1:0]      dry_acc, filt_acc;
    logic signed [STATE_W-1:0] high, band, low;
    logic signed [MW-1:0]      mix;
    logic signed [SCW-1:0]     scaled;
    logic                      valid_q;

    function automatic logic [10:0] res_lut(input logic [3:0] r);
        case (r)
            4'd0:  res_lut = 11'h5A8;
            4'd1:  res_lut = 11'h52B;
            4'd2:  res_lut = 11'h4C2;
            4'd3:  res_lut = 11'h468;
            4'd4:  res_lut = 11'h41B;
            4'd5:  res_lut = 11'h3D8;
            4'd6:  res_lut = 11'h39D;
            4'd7:  res_lut = 11'h368;
            4'd8:  res_lut = 11'h339;
            4'd9:  res_lut = 11'h30F;
            4'd10: res_lut = 11'h2E9;
            4'd11: res_lut = 11'h2C6;
            4'd12: res_lut = 11'h2A7;
            4'd13: res_lut = 11'h28A;
            4'd14: res_lut = 11'h270;
            default: res_lut = 11'h257;
        endcase
    endfunction

    // Sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ACC;
            vidx  <= '0;
        end else if (clk_enable) begin
            state <= state_next;
            vidx  <= vidx_next;
        end
    end

    always_comb begin
        state_next = state;
        vidx_next  = vidx;
        case (state)
            S_ACC: begin
                if (vidx == VW'(NUM_VOICES - 1)) begin
                    state_next = S_HIGH;
                    vidx_next  = '0;
                end else begin
                    vidx_next = vidx + 1'b1;
                end
            end
            S_HIGH:  state_next = S_LOW;
            S_LOW:   state_next = S_BAND;
            S_BAND:  state_next = S_MIX;
            S_MIX:   state_next = S_VOL;
            S_VOL:   state_next = S_OUT;
            default: state_next = S_ACC;
        endcase
    end

    // Voice accumulation; ACC(0) sees the live config since it is the capture cycle
    logic                     first;
    logic [SAMPLE_W-1:0]      cur_sample;
    logic                     cur_filt, cur_mute;
    logic signed [AW-1:0]     v_ext, dry_base, filt_base, dry_add, filt_add;

    always_comb begin
        first      = (vidx == '0);
        cur_sample = voice_samples[vidx*SAMPLE_W +: SAMPLE_W];
        cur_filt   = first ? filt_sel[0]   : filt_sh[vidx];
        cur_mute   = first ? voice_mute[0] : mute_sh[vidx];
        v_ext      = {{(AW-SAMPLE_W+1){~cur_sample[SAMPLE_W-1]}}, cur_sample[SAMPLE_W-2:0]};
        dry_base   = first ? '0 : dry_acc;
        filt_base  = first ? '0 : filt_acc;
        dry_add    = (!cur_filt && !cur_mute) ? v_ext : '0;
        filt_add   = cur_filt ? v_ext : '0;
    end

    // Single shared multiplier: res_coef*band in HIGH, fc_coef*band in LOW, fc_coef*high in BAND
    logic [FC_W+5:0]           fc_coef;
    logic signed [17:0]        mul_a;
    logic signed [STATE_W-1:0] mul_b;
    logic signed [PW-1:0]      prod, prod_s10, prod_s20;
    logic signed [STATE_W-1:0] m10, m20, fa_ext, high_next;

    always_comb begin
        fc_coef   = {fc_sh, 6'b0};
        mul_a     = (state == S_HIGH) ? $signed(18'(res_lut(res_sh))) : $signed(18'(fc_coef));
        mul_b     = (state == S_BAND) ? high : band;
        prod      = mul_a * mul_b;
        prod_s10  = prod >>> 10;
        prod_s20  = prod >>> 20;
        m10       = prod_s10[STATE_W-1:0];
        m20       = prod_s20[STATE_W-1:0];
        fa_ext    = {{(STATE_W-AW){filt_acc[AW-1]}}, filt_acc};
        high_next = m10 - low - (fa_ext <<< 1);
    end

    // Output mixing, volume and final reduction
    logic signed [MW-1:0]   hx, bx, lx, dx, tap_sum, mix_next;
    logic signed [MW+4:0]   vol_prod, vol_s4;
    logic signed [OUT_W-1:0] out_next;

    always_comb begin
        hx       = {{2{high[STATE_W-1]}}, high};
        bx       = {{2{band[STATE_W-1]}}, band};
        lx       = {{2{low[STATE_W-1]}}, low};
        dx       = {{(MW-AW){dry_acc[AW-1]}}, dry_acc};
        tap_sum  = (mode_sh[2] ? hx : '0) + (mode_sh[1] ? bx : '0) + (mode_sh[0] ? lx : '0);
        mix_next = dx + (tap_sum >>> 1);
        vol_prod = mix * $signed({1'b0, vol_sh});
        vol_s4   = vol_prod >>> 4;
`ifdef SID_SVF_SAT_EN
        if (scaled > OUT_MAX)
            out_next = OUT_MAX[OUT_W-1:0];
        else if (scaled < OUT_MIN)
            out_next = OUT_MIN[OUT_W-1:0];
        else
            out_next = scaled[OUT_W-1:0];
`else
        out_next = scaled[OUT_W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_sh    <= '0;
            mute_sh    <= '0;
            fc_sh      <= '0;
            res_sh     <= '0;
            vol_sh     <= '0;
            mode_sh    <= '0;
            dry_acc    <= '0;
            filt_acc   <= '0;
            high       <= '0;
            band       <= '0;
            low        <= '0;
            mix        <= '0;
            scaled     <= '0;
            sample_out <= '0;
            valid_q    <= 1'b0;
        end else if (clk_enable) begin
            valid_q <= (state == S_OUT);
            case (state)
                S_ACC: begin
                    if (first) begin
                        filt_sh <= filt_sel;
                        mute_sh <= voice_mute;
                        fc_sh   <= reg_fc;
                        res_sh  <= res;
                        mode_sh <= mode;
                        vol_sh  <= vol;
                    end
                    dry_acc  <= dry_base + dry_add;
                    filt_acc <= filt_base + filt_add;
                end
                S_HIGH:  high       <= high_next;
                S_LOW:   low        <= low - m20;
                S_BAND:  band       <= band - m20;
                S_MIX:   mix        <= mix_next;
                S_VOL:   scaled     <= vol_s4[SCW-1:0];
                default: sample_out <= out_next;
            endcase
        end
    end

    // Pulse is held through a stall and shown in the first enabled cycle after OUT
    assign sample_valid = valid_q & clk_enable;

endmodule

// File: tb/tb_sid_svf_mixer.sv
// Bench for sid_svf_mixer: directed cases plus randomized frames against a frame-level model.
module tb_sid_svf_mixer;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_enable;
    logic [35:0]        voice_samples;
    logic [2:0]         filt_sel, voice_mute, mode;
    logic [10:0]        reg_fc;
    logic [3:0]         res, vol;
    logic signed [15:0] out16;
    logic signed [11:0] out12;
    logic               val16, val12;

    int     vectors = 0;
    int     miscompares = 0;
    int     hi, bd, lo;
    longint exp16, exp12;
    int     rc_tab [16] = '{32'h5A8, 32'h52B, 32'h4C2, 32'h468, 32'h41B, 32'h3D8, 32'h39D, 32'h368,
                            32'h339, 32'h30F, 32'h2E9, 32'h2C6, 32'h2A7, 32'h28A, 32'h270, 32'h257};

    sid_svf_mixer u16 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .voice_samples(voice_samples),
        .filt_sel(filt_sel), .voice_mute(voice_mute), .reg_fc(reg_fc), .res(res),
        .mode(mode), .vol(vol), .sample_out(out16), .sample_valid(val16)
    );

    sid_svf_mixer #(.OUT_W(12)) u12 (
        .clk(clk), .rst(rst), .clk_enable(clk_enable), .voice_samples(voice_samples),
        .filt_sel(filt_sel), .voice_mute(voice_mute), .reg_fc(reg_fc), .res(res),
        .mode(mode), .vol(vol), .sample_out(out12), .sample_valid(val12)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint reduce(input longint x, input int w);
        longint mx, mn, m;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
`ifdef SID_SVF_SAT_EN
        m = (x > mx) ? mx : ((x < mn) ? mn : x);
`else
        m = x & ((longint'(1) <<< w) - 1);
        if (m > mx) m = m - (longint'(1) <<< w);
`endif
        return m;
    endfunction

    // One frame of the filter evaluated from the inputs as they stand at ACC(0)
    task automatic model_frame();
        longint dry, fa, fc, mix, sc;
        dry = 0;
        fa  = 0;
        for (int i = 0; i < 3; i++) begin
            int v;
            v = int'(voice_samples[i*12 +: 12]) - 2048;
            if (filt_sel[i]) fa += v;
            else if (!voice_mute[i]) dry += v;
        end
        fc  = longint'(reg_fc) * 64;
        hi  = int'((longint'(rc_tab[res]) * bd) >>> 10) - lo - 2 * int'(fa);
        lo  = lo - int'((fc * bd) >>> 20);
        bd  = bd - int'((fc * hi) >>> 20);
        mix = dry + (((mode[2] ? longint'(hi) : 0) + (mode[1] ? longint'(bd) : 0)
                     + (mode[0] ? longint'(lo) : 0)) >>> 1);
        sc  = (mix * longint'(vol)) >>> 4;
        exp16 = reduce(sc, 16);
        exp12 = reduce(sc, 12);
    endtask

    task automatic set_voices(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        voice_samples = {c, b, a};
    endtask

    task automatic model_reset();
        hi = 0; bd = 0; lo = 0; exp16 = 0; exp12 = 0;
    endtask

    // Runs one frame from the upcoming ACC(0) edge; optional stall and mid-frame config scramble
    task automatic run_frame(input string tag, input int stall_at, input int stall_len,
                             input int exp_period, input bit scramble);
        int     n;
        bit     got;
        longint prev16;
        n      = 0;
        got    = 0;
        prev16 = exp16;
        model_frame();
        while (!got && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (val16) got = 1;
            else if (n == 1) check({tag, "_pulse_width"}, val16, 0);
            if (scramble && n == 2) begin
                filt_sel   = 3'($urandom);
                voice_mute = 3'($urandom);
                reg_fc     = 11'($urandom);
                res        = 4'($urandom);
                mode       = 3'($urandom);
                vol        = 4'($urandom);
            end
            if (stall_at != 0 && n == stall_at && !got) begin
                clk_enable = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    check({tag, "_stall_valid"}, val16, 0);
                    check({tag, "_stall_hold"}, out16, prev16);
                end
                clk_enable = 1'b1;
            end
        end
        check({tag, "_valid_seen"}, got, 1);
        check({tag, "_period"}, n, exp_period);
        check({tag, "_out16"}, out16, exp16);
        check({tag, "_out12"}, out12, exp12);
        check({tag, "_valid12"}, val12, 1);
    endtask

    initial begin
        rst        = 1'b1;
        clk_enable = 1'b1;
        set_voices(12'h800, 12'h800, 12'h800);
        filt_sel   = '0;
        voice_mute = '0;
        reg_fc     = '0;
        res        = '0;
        mode       = '0;
        vol        = 4'd15;
        model_reset();

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("reset_out", out16, 0);
            check("reset_valid", val16, 0);
        end
        rst = 1'b0;

        run_frame("first", 0, 0, 9, 0);
        check("dry_zero", out16, 0);
        run_frame("dry_zero2", 0, 0, 9, 0);

        set_voices(12'hFFF, 12'h800, 12'h800);
        run_frame("dry_v0", 0, 0, 9, 0);
        check("dry_v0_const", out16, 1919);
        voice_mute = 3'b001;
        run_frame("mute_v0", 0, 0, 9, 0);
        check("mute_v0_const", out16, 0);

        // Reset mid-frame discards the partial frame
        voice_mute = '0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            check("pre_rst_valid", val16, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", val16, 0);
        check("mid_rst_out", out16, 0);
        rst = 1'b0;
        model_reset();

        filt_sel = 3'b001;
        mode     = 3'b100;
        run_frame("filt_hp", 0, 0, 9, 0);
        mode     = 3'b001;
        run_frame("filt_lp", 0, 0, 9, 0);
        check("filt_lp_const", out16, 0);

        filt_sel = '0;
        mode     = '0;
        set_voices(12'hFFF, 12'hFFF, 12'hFFF);
        run_frame("three_dry", 0, 0, 9, 0);
        check("three_dry_16", out16, 5757);
`ifdef SID_SVF_SAT_EN
        check("three_dry_12", out12, 2047);
`else
        check("three_dry_12", out12, 1661);
`endif

        set_voices(12'h123, 12'hABC, 12'h7FF);
        filt_sel = 3'b010;
        reg_fc   = 11'd400;
        res      = 4'd7;
        mode     = 3'b111;
        run_frame("stall", 3, 5, 14, 0);

        for (int k = 0; k < 40; k++) begin
            int sl;
            set_voices(12'($urandom), 12'($urandom), 12'($urandom));
            filt_sel   = 3'($urandom);
            voice_mute = 3'($urandom);
            reg_fc     = 11'($urandom_range(0, 2047));
            res        = 4'($urandom);
            mode       = 3'($urandom);
            vol        = 4'($urandom);
            sl         = (k % 10 == 9) ? int'($urandom_range(1, 6)) : 0;
            run_frame("rand", (sl != 0) ? 2 : 0, sl, 9 + sl, (k % 3 == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
